// File: rtl/st7735_lcd_driver.sv
// ST7735 write-only SPI controller: panel reset pulse, init command list, then
// RGB565 pixel streaming with RAMWR re-issued each time the frame wraps.
module st7735_lcd_driver #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int SPI_DIV         = 2,
  parameter int WIDTH           = 128,
  parameter int HEIGHT          = 160,
  parameter int MS_CYCLES       = CLOCK_SPEED_MHZ * 1000
) (
  input  logic        SYSTEM_CLK,
  input  logic        RST_N,
  input  logic [15:0] color_pixel,
  input  logic        WRITE_EN,
  output logic        IS_BUSY,
  output logic        LCD_READY,
  output logic        CS,
  output logic        MOSI,
  output logic        DC,
  output logic        LCD_CLK,
  output logic        RESET
);
  localparam int          DIV_W         = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int          NPIX          = WIDTH * HEIGHT;
  localparam int          PIX_W         = $clog2(NPIX + 1);
  localparam logic [4:0]  RAMWR_IDX     = 5'd17;
  localparam logic [31:0] MS_CYC        = 32'(MS_CYCLES);
  localparam logic [31:0] RST_LO_LAST   = 32'(10 * MS_CYCLES - 1);
  localparam logic [31:0] RST_WAIT_LAST = 32'(120 * MS_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RST_LO, ST_RST_WAIT, ST_LOAD, ST_SHIFT, ST_DELAY, ST_IDLE
  } state_t;

  // Entry layout: {last, dc, byte, delay after the byte in ms}
  function automatic logic [17:0] init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    init_rom = {1'b0, 1'b0, 8'h01, 8'd150};
      5'd1:    init_rom = {1'b0, 1'b0, 8'h11, 8'd120};
      5'd2:    init_rom = {1'b0, 1'b0, 8'h3A, 8'd0};
      5'd3:    init_rom = {1'b0, 1'b1, 8'h05, 8'd0};
      5'd4:    init_rom = {1'b0, 1'b0, 8'h36, 8'd0};
      5'd5:    init_rom = {1'b0, 1'b1, 8'h00, 8'd0};
      5'd6:    init_rom = {1'b0, 1'b0, 8'h2A, 8'd0};
      5'd7,
      5'd8,
      5'd9:    init_rom = {1'b0, 1'b1, 8'h00, 8'd0};
      5'd10:   init_rom = {1'b0, 1'b1, 8'(WIDTH - 1), 8'd0};
      5'd11:   init_rom = {1'b0, 1'b0, 8'h2B, 8'd0};
      5'd12,
      5'd13,
      5'd14:   init_rom = {1'b0, 1'b1, 8'h00, 8'd0};
      5'd15:   init_rom = {1'b0, 1'b1, 8'(HEIGHT - 1), 8'd0};
      5'd16:   init_rom = {1'b0, 1'b0, 8'h29, 8'd10};
      5'd17:   init_rom = {1'b1, 1'b0, 8'h2C, 8'd0};
      default: init_rom = '0;
    endcase
  endfunction

  logic [DIV_W-1:0] r_div;
  logic             r_sclk;
  logic             w_fall;

  state_t           r_state;
  logic [4:0]       r_idx;
  logic [15:0]      r_shift;
  logic [4:0]       r_bits;
  logic             r_byte_dc;
  logic             r_is_pix;
  logic [31:0]      r_wait;
  logic [31:0]      r_wait_lim;
  logic [PIX_W-1:0] r_pix_cnt;
  logic             r_cs, r_mosi, r_dc, r_reset, r_ready, r_busy;

  logic [17:0]      w_rom;
  logic             w_last, w_dc;
  logic [7:0]       w_byte, w_ms;

  assign w_rom  = init_rom(r_idx);
  assign w_last = w_rom[17];
  assign w_dc   = w_rom[16];
  assign w_byte = w_rom[15:8];
  assign w_ms   = w_rom[7:0];

  // Free-running SPI clock; all panel-side outputs move on its falling edge.
  assign w_fall = (r_div == DIV_W'(SPI_DIV - 1)) && r_sclk;

  always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (r_div == DIV_W'(SPI_DIV - 1)) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_RST_LO;
      r_idx      <= '0;
      r_shift    <= '0;
      r_bits     <= '0;
      r_byte_dc  <= 1'b0;
      r_is_pix   <= 1'b0;
      r_wait     <= '0;
      r_wait_lim <= '0;
      r_pix_cnt  <= '0;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
      r_dc       <= 1'b0;
      r_reset    <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_RST_LO: begin
          if (r_wait == RST_LO_LAST) begin
            r_wait  <= '0;
            r_reset <= 1'b1;
            r_state <= ST_RST_WAIT;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        ST_RST_WAIT: begin
          if (r_wait == RST_WAIT_LAST) begin
            r_wait  <= '0;
            r_idx   <= '0;
            r_state <= ST_LOAD;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        ST_LOAD: begin
          r_shift   <= {w_byte, 8'h00};
          r_bits    <= 5'd8;
          r_byte_dc <= w_dc;
          r_is_pix  <= 1'b0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_fall) begin
            if (r_bits != 5'd0) begin
              r_cs    <= 1'b0;
              r_dc    <= r_byte_dc;
              r_mosi  <= r_shift[15];
              r_shift <= {r_shift[14:0], 1'b0};
              r_bits  <= r_bits - 5'd1;
            end else begin
              // Raising CS here and loading the next word afterwards gives the
              // one-LCD_CLK CS-high gap between bytes.
              r_cs   <= 1'b1;
              r_mosi <= 1'b0;
              if (r_is_pix) begin
                if (r_pix_cnt == PIX_W'(NPIX - 1)) begin
                  r_pix_cnt <= '0;
                  r_idx     <= RAMWR_IDX;
                  r_state   <= ST_LOAD;
                end else begin
                  r_pix_cnt <= r_pix_cnt + 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= ST_IDLE;
                end
              end else if (w_last) begin
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else if (w_ms != 8'd0) begin
                r_wait     <= '0;
                r_wait_lim <= 32'(w_ms) * MS_CYC - 32'd1;
                r_idx      <= r_idx + 5'd1;
                r_state    <= ST_DELAY;
              end else begin
                r_idx   <= r_idx + 5'd1;
                r_state <= ST_LOAD;
              end
            end
          end
        end
        ST_DELAY: begin
          if (r_wait == r_wait_lim) begin
            r_wait  <= '0;
            r_state <= ST_LOAD;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        ST_IDLE: begin
          if (WRITE_EN) begin
            r_shift   <= color_pixel;
            r_bits    <= 5'd16;
            r_byte_dc <= 1'b1;
            r_is_pix  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        default: r_state <= ST_RST_LO;
      endcase
    end
  end

  assign IS_BUSY   = r_busy;
  assign LCD_READY = r_ready;
  assign CS        = r_cs;
  assign MOSI      = r_mosi;
  assign DC        = r_dc;
  assign LCD_CLK   = r_sclk;
  assign RESET     = r_reset;
endmodule

// File: tb/tb_st7735_lcd_driver.sv
// Scoreboard bench for st7735_lcd_driver: decodes SPI frames off the pins and
// matches them against an expected queue filled from reset releases and pixel handshakes.
module tb_st7735_lcd_driver;
  localparam int SPI_DIV   = 2;
  localparam int WIDTH     = 4;
  localparam int HEIGHT    = 3;
  localparam int MS_CYCLES = 20;
  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int PERIOD    = 2 * SPI_DIV;

  logic        SYSTEM_CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] color_pixel = 16'h0000;
  logic        WRITE_EN = 1'b0;
  logic        IS_BUSY, LCD_READY, CS, MOSI, DC, LCD_CLK, RESET;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic        dc;
    int          bits;
    logic [15:0] val;
    logic        busy;
    logic        last;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  st7735_lcd_driver #(
    .CLOCK_SPEED_MHZ(12), .SPI_DIV(SPI_DIV), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MS_CYCLES(MS_CYCLES)
  ) dut (
    .SYSTEM_CLK(SYSTEM_CLK), .RST_N(RST_N), .color_pixel(color_pixel), .WRITE_EN(WRITE_EN),
    .IS_BUSY(IS_BUSY), .LCD_READY(LCD_READY), .CS(CS), .MOSI(MOSI), .DC(DC),
    .LCD_CLK(LCD_CLK), .RESET(RESET)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;
  always @(posedge SYSTEM_CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic dc, input int bits, input logic [15:0] val,
                          input logic busy, input logic last, input int acc);
    exp_t e;
    e.dc = dc; e.bits = bits; e.val = val; e.busy = busy; e.last = last; e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    logic [8:0] lst [18];
    lst = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h036, 9'h100, 9'h02A, 9'h100, 9'h100,
            9'h100, 9'h100 | 9'(WIDTH - 1), 9'h02B, 9'h100, 9'h100, 9'h100,
            9'h100 | 9'(HEIGHT - 1), 9'h029, 9'h02C};
    for (int i = 0; i < 18; i++)
      push_exp(lst[i][8], 8, {8'h00, lst[i][7:0]}, (i != 17), (i == 17), 0);
  endtask

  // Frame decoder state
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_rst = 1'b0;
  logic        m_dc = 1'b0, m_dc_bad = 1'b0, model_ready = 1'b0;
  logic [31:0] m_val = '0;
  int          m_bits = 0, last_rise = -1000, frame_no = 0, model_cnt = 0;

  task automatic frame_end();
    string t;
    exp_t  e;
    t = $sformatf("frame%0d", frame_no);
    frame_no++;
    if (exp_q.size() == 0) begin
      check_val({t, "_expected"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_val({t, "_dc"}, 32'(m_dc), 32'(e.dc));
      check_val({t, "_bits"}, m_bits, e.bits);
      check_val({t, "_data"}, m_val, 32'(e.val));
      check_val({t, "_dc_stable"}, 32'(m_dc_bad), 0);
      check_val({t, "_busy_after"}, 32'(IS_BUSY), 32'(e.busy));
      if (e.bits == 16)
        check_val({t, "_latency_ok"}, 32'((cyc - e.acc) <= 17 * PERIOD + 1), 1);
      if (e.last) begin
        check_val({t, "_lcd_ready"}, 32'(LCD_READY), 1);
        model_ready = 1'b1;
      end
      $display("frame %0d: dc=%0b bits=%0d data=%h", frame_no - 1, m_dc, m_bits, m_val);
    end
  endtask

  always @(negedge SYSTEM_CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      model_ready = 1'b0; model_cnt = 0;
      m_bits = 0; m_val = '0; m_dc_bad = 1'b0;
      prev_sclk = 1'b0; prev_cs = 1'b1; last_rise = -1000;
    end else begin
      if (!prev_rst) push_init();
      if (!CS && prev_cs)
        check_val("cs_gap_ok", 32'((cyc - last_rise) >= PERIOD), 1);
      if (LCD_CLK && !prev_sclk && !CS) begin
        if (m_bits == 0) m_dc = DC;
        else if (DC !== m_dc) m_dc_bad = 1'b1;
        m_val = {m_val[30:0], MOSI};
        m_bits++;
      end
      if (CS && !prev_cs) begin
        last_rise = cyc;
        frame_end();
        m_bits = 0; m_val = '0; m_dc_bad = 1'b0;
      end
      if (WRITE_EN && !IS_BUSY && model_ready) begin
        push_exp(1'b1, 16, color_pixel, (model_cnt == NPIX - 1), 1'b0, cyc);
        model_cnt++;
        if (model_cnt == NPIX) begin
          model_cnt = 0;
          push_exp(1'b0, 8, 16'h002C, 1'b0, 1'b0, 0);
        end
      end
      prev_sclk = LCD_CLK;
      prev_cs   = CS;
    end
    prev_rst = RST_N;
  end

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && !LCD_READY; i++) @(posedge SYSTEM_CLK);
    #1;
    check_val("lcd_ready", 32'(LCD_READY), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && (IS_BUSY || !CS); i++) @(posedge SYSTEM_CLK);
    repeat (4) @(posedge SYSTEM_CLK);
    #1;
    check_val("idle_busy", 32'(IS_BUSY), 0);
    check_val("queue_drained", exp_q.size(), 0);
  endtask

  // Holds WRITE_EN until n pixels are accepted; advances color_pixel on each IS_BUSY fall.
  task automatic send_stream(input int n, input logic [15:0] start);
    int   acc = 0;
    int   t = 0;
    logic pb;
    @(posedge SYSTEM_CLK); #2;
    color_pixel = start;
    WRITE_EN = 1'b1;
    pb = IS_BUSY;
    while (acc < n && t < 100 * n * PERIOD) begin
      @(posedge SYSTEM_CLK); #2;
      t++;
      if (IS_BUSY && !pb) begin
        acc++;
        if (acc == n) WRITE_EN = 1'b0;
      end else if (!IS_BUSY && pb) begin
        color_pixel = color_pixel + 16'd1;
      end
      pb = IS_BUSY;
    end
    WRITE_EN = 1'b0;
    check_val("stream_accepted", acc, n);
  endtask

  initial begin
    int n;
    RST_N = 1'b0; WRITE_EN = 1'b1; color_pixel = 16'hABCD;
    repeat (3) @(posedge SYSTEM_CLK);
    #1;
    check_val("rst_cs", 32'(CS), 1);
    check_val("rst_mosi", 32'(MOSI), 0);
    check_val("rst_dc", 32'(DC), 0);
    check_val("rst_lcd_clk", 32'(LCD_CLK), 0);
    check_val("rst_reset", 32'(RESET), 0);
    check_val("rst_ready", 32'(LCD_READY), 0);
    check_val("rst_busy", 32'(IS_BUSY), 1);

    @(posedge SYSTEM_CLK); #3;
    RST_N = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(posedge SYSTEM_CLK); #1;
      n++;
      if (RESET) break;
    end
    check_val("reset_low_cycles", n, 10 * MS_CYCLES);

    // WRITE_EN stays high through init and is dropped before RAMWR goes out.
    for (int i = 0; i < 20000 && frame_no < 17; i++) @(posedge SYSTEM_CLK);
    #2;
    WRITE_EN = 1'b0;
    check_val("init_frames_seen", frame_no, 17);
    wait_ready(5000);
    wait_idle();

    send_stream(1, 16'hF81F);
    wait_idle();

    // 14 more pixels cross the 12-pixel frame wrap, forcing a RAMWR mid-stream.
    send_stream(14, 16'h0000);
    wait_idle();

    @(posedge SYSTEM_CLK); #2;
    color_pixel = 16'h5A5A;
    WRITE_EN = 1'b1;
    for (int i = 0; i < 50 && !IS_BUSY; i++) begin
      @(posedge SYSTEM_CLK); #2;
    end
    WRITE_EN = 1'b0;
    repeat (20) @(posedge SYSTEM_CLK);
    #1;
    check_val("cs_low_mid_pixel", 32'(CS), 0);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("abort_cs", 32'(CS), 1);
    check_val("abort_reset", 32'(RESET), 0);
    check_val("abort_ready", 32'(LCD_READY), 0);
    check_val("abort_busy", 32'(IS_BUSY), 1);
    repeat (3) @(posedge SYSTEM_CLK);
    #3;
    RST_N = 1'b1;
    wait_ready(15000);
    wait_idle();

    send_stream(1, 16'h1234);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
